// File: rtl/reg_shift_mux_pkg.sv
// rtl/reg_shift_mux_pkg.sv - shared defaults and mux select encodings for reg_shift_mux
package reg_shift_mux_pkg;

   localparam int          DEF_SIZE      = 16;
   localparam int unsigned DEF_RESET_VAL = 0;

   localparam logic MUX_SEL_BYPASS = 1'b0;
   localparam logic MUX_SEL_REG    = 1'b1;

endpackage

// File: rtl/reg_shift_mux_mux2_word.sv
// rtl/reg_shift_mux_mux2_word.sv - word-wide 2:1 combinational multiplexer
module mux2_word #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sel,
   output logic [WIDTH-1:0] c
);

   assign c = sel ? b : a;

endmodule

// File: rtl/reg_shift_mux.sv
// rtl/reg_shift_mux.sv - holding register with load/shift/clear and output select mux
// Serial shift paths exist only when REG_SHIFT_EN is defined.
module reg_shift_mux
   import reg_shift_mux_pkg::*;
#(
   parameter int              SIZE      = DEF_SIZE,
   parameter logic [SIZE-1:0] RESET_VAL = SIZE'(DEF_RESET_VAL)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ld_en,
   input  logic            right_shen,
   input  logic            left_shen,
   input  logic            ser_in,
   input  logic [SIZE-1:0] inval,
   output logic [SIZE-1:0] outval,
   output logic            msb,
   input  logic [SIZE-1:0] mux_a,
   input  logic            mux_sel,
   output logic [SIZE-1:0] mux_out
);

   logic [SIZE-1:0] q;

`ifdef REG_SHIFT_EN
   // Right shift outranks left shift when both enables are asserted.
   always_ff @(posedge clk) begin
      if (rst)
         q <= RESET_VAL;
      else if (ld_en)
         q <= inval;
      else if (right_shen)
         q <= {ser_in, q[SIZE-1:1]};
      else if (left_shen)
         q <= {q[SIZE-2:0], ser_in};
   end
`else
   // Shift controls stay on the port list so instantiations match both builds.
   logic unused_shift_ctl;
   assign unused_shift_ctl = ^{right_shen, left_shen, ser_in};

   always_ff @(posedge clk) begin
      if (rst)
         q <= RESET_VAL;
      else if (ld_en)
         q <= inval;
   end
`endif

   assign outval = q;
   assign msb    = q[SIZE-1];

   mux2_word #(
      .WIDTH (SIZE)
   ) u_out_mux (
      .a   (mux_a),
      .b   (outval),
      .sel (mux_sel),
      .c   (mux_out)
   );

endmodule

// File: tb/tb_reg_shift_mux.sv
// tb/tb_reg_shift_mux.sv - scoreboard bench for reg_shift_mux, covers both REG_SHIFT_EN builds
module tb_reg_shift_mux;
   import reg_shift_mux_pkg::*;

   localparam int SIZE = 16;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            ld_en = 1'b0;
   logic            right_shen = 1'b0;
   logic            left_shen = 1'b0;
   logic            ser_in = 1'b0;
   logic [SIZE-1:0] inval = '0;
   logic [SIZE-1:0] outval;
   logic            msb;
   logic [SIZE-1:0] mux_a = '0;
   logic            mux_sel = MUX_SEL_BYPASS;
   logic [SIZE-1:0] mux_out;

   typedef struct {
      int              id;
      logic [SIZE-1:0] outval;
      logic            msb;
      logic [SIZE-1:0] mux_out;
   } exp_t;

   exp_t sb[$];
   int   n_vec  = 0;
   int   n_miss = 0;
   int   vec_id = 0;

`ifdef REG_SHIFT_EN
   localparam bit SHIFT_ON = 1'b1;
`else
   localparam bit SHIFT_ON = 1'b0;
`endif

   always #5 clk = ~clk;

   reg_shift_mux #(
      .SIZE      (SIZE),
      .RESET_VAL (16'h0000)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ld_en      (ld_en),
      .right_shen (right_shen),
      .left_shen  (left_shen),
      .ser_in     (ser_in),
      .inval      (inval),
      .outval     (outval),
      .msb        (msb),
      .mux_a      (mux_a),
      .mux_sel    (mux_sel),
      .mux_out    (mux_out)
   );

   // Drive one cycle of inputs and queue the register value expected after the edge.
   task automatic apply(input logic r, input logic ld, input logic rs, input logic ls,
                        input logic si, input logic [SIZE-1:0] d, input logic [SIZE-1:0] a,
                        input logic sel, input logic [SIZE-1:0] exp_q);
      exp_t e;
      @(negedge clk);
      rst = r; ld_en = ld; right_shen = rs; left_shen = ls; ser_in = si;
      inval = d; mux_a = a; mux_sel = sel;
      e.id      = vec_id;
      e.outval  = exp_q;
      e.msb     = exp_q[SIZE-1];
      e.mux_out = sel ? exp_q : a;
      sb.push_back(e);
      vec_id++;
   endtask

   always @(posedge clk) begin
      #1;
      if (sb.size() > 0) begin
         exp_t e;
         bit   bad;
         e   = sb.pop_front();
         bad = 1'b0;
         n_vec++;
         if (outval !== e.outval) begin
            $display("FAIL vec%0d outval: got %h expected %h", e.id, outval, e.outval);
            bad = 1'b1;
         end
         if (msb !== e.msb) begin
            $display("FAIL vec%0d msb: got %b expected %b", e.id, msb, e.msb);
            bad = 1'b1;
         end
         if (mux_out !== e.mux_out) begin
            $display("FAIL vec%0d mux_out: got %h expected %h", e.id, mux_out, e.mux_out);
            bad = 1'b1;
         end
         if (bad) n_miss++;
      end
   end

   initial begin
      //     rst  ld   rs   ls   si   inval     mux_a     sel  expected q
      apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'hBEEF, 16'h0000, 1'b1, 16'h0000);
      apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h8001, 16'h0000, 1'b1, 16'h8001);
      apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 1'b1, 16'h8001);
      apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1, 16'h8001);
      apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1111, 16'h0000, 1'b1, 16'h8001);
      apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, SHIFT_ON ? 16'h4000 : 16'h8001);
      apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000, 1'b1, 16'h8001);
      apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h0000, 1'b1, SHIFT_ON ? 16'hC000 : 16'h8001);
      apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h1234, 16'h0000, 1'b1, 16'h1234);
      apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h5555, 16'hAAAA, 1'b0, 16'h5555);
      apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'hAAAA, 1'b1, 16'h5555);
      apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'hAAAA, 1'b0, 16'h5555);
      apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h3C3C, 1'b1, 16'h5555);
      apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h00F0, 16'h0000, 1'b1, 16'h00F0);
      apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1, SHIFT_ON ? 16'h8078 : 16'h00F0);
      apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h00F0);
      apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h8000, 16'h0000, 1'b1, 16'h8000);
      apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, SHIFT_ON ? 16'h0000 : 16'h8000);
      apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0F0F, 16'h0000, 1'b0, 16'h0F0F);
      apply(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'hFFFF, 16'h7E7E, 1'b1, 16'h0000);
      apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h7E7E, 1'b0, 16'h0000);

      @(negedge clk);
      rst = 1'b0; ld_en = 1'b0; right_shen = 1'b0; left_shen = 1'b0;
      for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
      if (sb.size() > 0) begin
         $display("FAIL drain: %0d expected entries left, required 0", sb.size());
         n_miss++;
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
